sdram_burst_master: RTL and testbench

Client-side initiator for the SDRAM controller top-level. It buffers a streaming write source in an internal FIFO, issues fixed-length write bursts to the controller's write request/ack port, and forwards client read requests to the controller's read port, returning read words with a valid strobe. It drives the controller's system-side ports and sits between the controller and pixel or CPU clients.

---
 rtl/sdram_burst_master.sv | 196 +++++++++++++++++++
 tb/tb_sdram_burst_master.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_burst_master.sv
// Client-side SDRAM initiator: show-ahead write FIFO drained in fixed bursts, plus a single-outstanding read path.
// Define SDRAM_MASTER_WRAP_EN to wrap the write pointer inside [WR_BASE, WR_BASE+WR_SIZE).
module sdram_burst_master #(
  parameter int          BURST_LEN = 16,
  parameter int          FIFO_AW   = 6,
  parameter logic [23:0] WR_BASE   = 24'h000000,
  parameter logic [23:0] WR_SIZE   = 24'h010000,
  parameter int          RD_DLY    = 2
) (
  input  logic        clk_100m,
  input  logic        rst_n,
  input  logic        cli_wr_en,
  input  logic [15:0] cli_wr_data,
  output logic        cli_wr_full,
  input  logic        cli_flush,
  output logic        cli_ovf,
  input  logic        cli_rd_req,
  input  logic [23:0] cli_rd_addr,
  input  logic [8:0]  cli_rd_len,
  output logic        cli_rd_busy,
  output logic [15:0] cli_rd_data,
  output logic        cli_rd_valid,
  input  logic        sdram_init_done,
  input  logic        sdram_busy,
  output logic [23:0] sdram_wr_addr,
  output logic [15:0] sdram_wr_data,
  output logic        sdram_wr_req,
  output logic [8:0]  sdwr_bytes,
  input  logic        sdram_wr_ack,
  output logic [23:0] sdram_rd_addr,
  output logic        sdram_rd_req,
  output logic [8:0]  sdrd_bytes,
  input  logic [15:0] sdram_rd_data,
  input  logic        sdram_rd_ack
);
`ifdef SDRAM_MASTER_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif
  localparam int          DEPTH   = 1 << FIFO_AW;
  localparam int          CW      = FIFO_AW + 1;
  localparam logic [CW-1:0] BL_C    = CW'(BURST_LEN);
  localparam logic [CW-1:0] HI_WM   = CW'(DEPTH - BURST_LEN);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [23:0] WR_END  = WR_BASE + WR_SIZE;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_REQ, WR_DATA, DRAIN} state_t;
  state_t state_q, state_d;

  logic [15:0]        fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] fwr_q, frd_q;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               full_q, ovf_q, flush_q;
  logic               push, pop;
  logic [8:0]         beat_q, beat_d, cur_len, wr_len_c;
  logic               ack_cur, wr_ready, wr_urgent, is_rd, is_wr;
  logic               rd_pend_q, rd_fly_q, rd_busy, rd_tap, rd_sh_busy;
  logic [23:0]        rd_pend_addr_q, wr_ptr_q, wr_ptr_sum, wr_ptr_nxt, room_c;
  logic [8:0]         rd_pend_len_q;
  logic [23:0]        wr_addr_q, rd_addr_q;
  logic [8:0]         wr_bytes_q, rd_bytes_q;
  logic               rd_valid_q;
  logic [15:0]        rd_data_q;

  assign is_rd   = (state_q == RD_REQ) || (state_q == RD_DATA);
  assign is_wr   = (state_q == WR_REQ) || (state_q == WR_DATA);
  assign push    = cli_wr_en && !full_q;
  assign pop     = sdram_wr_ack && is_wr && (cnt_q != '0);
  assign cnt_d   = cnt_q + CW'(push) - CW'(pop);
  assign ack_cur = (is_rd && sdram_rd_ack) || (is_wr && sdram_wr_ack);
  assign cur_len = is_rd ? rd_bytes_q : wr_bytes_q;
  assign wr_ready  = (cnt_q >= BL_C) || (flush_q && (cnt_q != '0));
  assign wr_urgent = (cnt_q >= HI_WM);
  assign rd_busy   = rd_pend_q || rd_fly_q || rd_sh_busy;

  // Burst length: full burst when available, else the flush residue; clipped at the region end when wrapping.
  assign room_c = WR_END - wr_ptr_q;
  always_comb begin
    wr_len_c = (cnt_q >= BL_C) ? 9'(BURST_LEN) : 9'(cnt_q);
    if (WRAP_EN && (room_c < 24'(wr_len_c)))
      wr_len_c = room_c[8:0];
  end

  assign wr_ptr_sum = wr_ptr_q + 24'(wr_bytes_q);
  assign wr_ptr_nxt = (WRAP_EN && (wr_ptr_sum == WR_END)) ? WR_BASE : wr_ptr_sum;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q + 9'(ack_cur);
    if (state_q == IDLE) beat_d = '0;
    case (state_q)
      IDLE: begin
        if (sdram_init_done && !sdram_busy) begin
          if (rd_pend_q && !(wr_ready && wr_urgent)) state_d = RD_REQ;
          else if (wr_ready)                         state_d = WR_REQ;
        end
      end
      RD_REQ:           if (ack_cur) state_d = RD_DATA;
      WR_REQ:           if (ack_cur) state_d = WR_DATA;
      RD_DATA, WR_DATA: if (beat_d == cur_len) state_d = DRAIN;
      DRAIN:            if (!sdram_busy) state_d = IDLE;
      default:          state_d = IDLE;
    endcase
  end

  // Storage has no reset; clearing the pointers is what discards the contents.
  always_ff @(posedge clk_100m) begin
    if (push) fifo_mem[fwr_q] <= cli_wr_data;
  end
  assign sdram_wr_data = fifo_mem[frd_q];

  generate
    if (RD_DLY > 0) begin : g_dly
      logic [RD_DLY-1:0] sh_q;
      always_ff @(posedge clk_100m) begin
        if (!rst_n) begin
          sh_q <= '0;
        end else begin
          sh_q[0] <= sdram_rd_ack;
          for (int i = 1; i < RD_DLY; i++) sh_q[i] <= sh_q[i-1];
        end
      end
      assign rd_tap     = sh_q[RD_DLY-1];
      assign rd_sh_busy = |sh_q;
    end else begin : g_nodly
      assign rd_tap     = sdram_rd_ack;
      assign rd_sh_busy = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk_100m) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      beat_q         <= '0;
      fwr_q          <= '0;
      frd_q          <= '0;
      cnt_q          <= '0;
      full_q         <= 1'b0;
      ovf_q          <= 1'b0;
      flush_q        <= 1'b0;
      rd_pend_q      <= 1'b0;
      rd_pend_addr_q <= '0;
      rd_pend_len_q  <= '0;
      rd_fly_q       <= 1'b0;
      wr_ptr_q       <= WR_BASE;
      wr_addr_q      <= WR_BASE;
      wr_bytes_q     <= 9'(BURST_LEN);
      rd_addr_q      <= '0;
      rd_bytes_q     <= '0;
      rd_valid_q     <= 1'b0;
      rd_data_q      <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (push) fwr_q <= fwr_q + FIFO_AW'(1);
      if (pop)  frd_q <= frd_q + FIFO_AW'(1);
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == DEPTH_C);
      if (cli_wr_en && full_q) ovf_q <= 1'b1;
      // Flush stays armed until the FIFO runs dry; arming on an empty FIFO is a no-op.
      flush_q <= (flush_q || cli_flush) && (cnt_d != '0);
      if (cli_rd_req && !rd_busy) begin
        rd_pend_q      <= 1'b1;
        rd_pend_addr_q <= cli_rd_addr;
        rd_pend_len_q  <= (cli_rd_len == '0) ? 9'd1 : cli_rd_len;
      end
      if (state_q == IDLE && state_d == RD_REQ) begin
        rd_addr_q  <= rd_pend_addr_q;
        rd_bytes_q <= rd_pend_len_q;
        rd_pend_q  <= 1'b0;
        rd_fly_q   <= 1'b1;
      end
      if (state_q == RD_DATA && state_d == DRAIN) rd_fly_q <= 1'b0;
      if (state_q == IDLE && state_d == WR_REQ) begin
        wr_addr_q  <= wr_ptr_q;
        wr_bytes_q <= wr_len_c;
      end
      if (state_q == WR_DATA && state_d == DRAIN) wr_ptr_q <= wr_ptr_nxt;
      rd_valid_q <= rd_tap;
      if (rd_tap) rd_data_q <= sdram_rd_data;
    end
  end

  assign cli_wr_full   = full_q;
  assign cli_ovf       = ovf_q;
  assign cli_rd_busy   = rd_busy;
  assign cli_rd_data   = rd_data_q;
  assign cli_rd_valid  = rd_valid_q;
  assign sdram_wr_addr = wr_addr_q;
  assign sdram_wr_req  = (state_q == WR_REQ);
  assign sdwr_bytes    = wr_bytes_q;
  assign sdram_rd_addr = rd_addr_q;
  assign sdram_rd_req  = (state_q == RD_REQ);
  assign sdrd_bytes    = rd_bytes_q;
endmodule

// File: tb/tb_sdram_burst_master.sv
// Self-checking bench for sdram_burst_master: queue-based model of FIFO, burst addressing and read return.
module tb_sdram_burst_master;
  localparam int          BL     = 16;
  localparam int          AW     = 6;
  localparam int          DEPTH  = 64;
  localparam int          RD_DLY = 2;
  localparam logic [23:0] WR_BASE = 24'h000000;
  localparam logic [23:0] WR_SIZE = 24'd24;
`ifdef SDRAM_MASTER_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic        clk_100m = 1'b0;
  logic        rst_n;
  logic        cli_wr_en, cli_flush, cli_rd_req;
  logic [15:0] cli_wr_data;
  logic [23:0] cli_rd_addr;
  logic [8:0]  cli_rd_len;
  logic        cli_wr_full, cli_ovf, cli_rd_busy, cli_rd_valid;
  logic [15:0] cli_rd_data;
  logic        sdram_init_done, sdram_busy, sdram_wr_ack, sdram_rd_ack;
  logic [23:0] sdram_wr_addr, sdram_rd_addr;
  logic [15:0] sdram_wr_data, sdram_rd_data;
  logic        sdram_wr_req, sdram_rd_req;
  logic [8:0]  sdwr_bytes, sdrd_bytes;

  sdram_burst_master #(
    .BURST_LEN(BL), .FIFO_AW(AW), .WR_BASE(WR_BASE), .WR_SIZE(WR_SIZE), .RD_DLY(RD_DLY)
  ) dut (
    .clk_100m(clk_100m), .rst_n(rst_n),
    .cli_wr_en(cli_wr_en), .cli_wr_data(cli_wr_data), .cli_wr_full(cli_wr_full),
    .cli_flush(cli_flush), .cli_ovf(cli_ovf),
    .cli_rd_req(cli_rd_req), .cli_rd_addr(cli_rd_addr), .cli_rd_len(cli_rd_len),
    .cli_rd_busy(cli_rd_busy), .cli_rd_data(cli_rd_data), .cli_rd_valid(cli_rd_valid),
    .sdram_init_done(sdram_init_done), .sdram_busy(sdram_busy),
    .sdram_wr_addr(sdram_wr_addr), .sdram_wr_data(sdram_wr_data), .sdram_wr_req(sdram_wr_req),
    .sdwr_bytes(sdwr_bytes), .sdram_wr_ack(sdram_wr_ack),
    .sdram_rd_addr(sdram_rd_addr), .sdram_rd_req(sdram_rd_req), .sdrd_bytes(sdrd_bytes),
    .sdram_rd_data(sdram_rd_data), .sdram_rd_ack(sdram_rd_ack)
  );

  always #5 clk_100m = ~clk_100m;

  int cyc = 0;
  always @(posedge clk_100m) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [15:0] wq[$];
  logic [23:0] wptr_m;
  bit          flush_m;
  bit          rd_pend_m;
  logic [23:0] rd_addr_m;
  int          rd_len_m;
  typedef struct { int c; logic [15:0] d; } ev_t;
  ev_t sched[$];
  ev_t expq[$];

  // Controller read-data driver and read-return checker
  always @(negedge clk_100m) begin
    bit   ev;
    ev_t  e;
    ev = (expq.size() > 0) && (expq[0].c == cyc);
    if (rst_n && (cli_rd_valid || ev)) begin
      check("rd_valid", {31'd0, cli_rd_valid}, {31'd0, ev});
      if (ev) check("rd_data", {16'd0, cli_rd_data}, {16'd0, expq[0].d});
    end
    if (ev) void'(expq.pop_front());
    if (sched.size() > 0 && sched[0].c == cyc) begin
      sdram_rd_data = sched[0].d;
      e.c = cyc + 1;
      e.d = sched[0].d;
      expq.push_back(e);
      void'(sched.pop_front());
    end else begin
      sdram_rd_data = 16'($urandom);
    end
  end

  task automatic tick();
    @(negedge clk_100m);
  endtask

  task automatic push_word();
    logic [15:0] d;
    d = 16'($urandom);
    cli_wr_en = 1'b1;
    cli_wr_data = d;
    if (wq.size() < DEPTH) wq.push_back(d);
    tick();
    cli_wr_en = 1'b0;
  endtask

  task automatic pulse_read(logic [23:0] a, logic [8:0] l);
    cli_rd_req = 1'b1;
    cli_rd_addr = a;
    cli_rd_len = l;
    if (!rd_pend_m) begin
      rd_pend_m = 1'b1;
      rd_addr_m = a;
      rd_len_m  = (l == 0) ? 1 : int'(l);
    end
    tick();
    cli_rd_req = 1'b0;
  endtask

  task automatic pulse_flush();
    cli_flush = 1'b1;
    if (wq.size() > 0) flush_m = 1'b1;
    tick();
    cli_flush = 1'b0;
  endtask

  function automatic bit wr_ready_m();
    return (wq.size() >= BL) || (flush_m && wq.size() > 0);
  endfunction

  task automatic wait_req(output int kind);
    kind = 0;
    for (int i = 0; i < 60; i++) begin
      if (sdram_rd_req || sdram_wr_req) begin
        kind = sdram_rd_req ? 1 : 2;
        return;
      end
      tick();
    end
  endtask

  task automatic serve_write();
    int len;
    logic [23:0] room;
    len = (wq.size() >= BL) ? BL : wq.size();
    room = WR_BASE + WR_SIZE - wptr_m;
    if (WRAP && room < len) len = int'(room);
    check("wr_addr", {8'd0, sdram_wr_addr}, {8'd0, wptr_m});
    check("wr_bytes", {23'd0, sdwr_bytes}, len);
    for (int i = 0; i < len; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      sdram_wr_ack = 1'b1;
      check("wr_data", {16'd0, sdram_wr_data}, {16'd0, wq[0]});
      void'(wq.pop_front());
      tick();
      sdram_wr_ack = 1'b0;
    end
    wptr_m = wptr_m + 24'(len);
    if (WRAP && wptr_m == WR_BASE + WR_SIZE) wptr_m = WR_BASE;
    if (wq.size() == 0) flush_m = 1'b0;
    tick();
    check("wr_req_drop", {31'd0, sdram_wr_req}, 0);
  endtask

  task automatic serve_read(bit try_drop);
    ev_t e;
    check("rd_addr", {8'd0, sdram_rd_addr}, {8'd0, rd_addr_m});
    check("rd_bytes", {23'd0, sdrd_bytes}, rd_len_m);
    check("rd_busy_fly", {31'd0, cli_rd_busy}, 1);
    rd_pend_m = 1'b0;
    for (int i = 0; i < rd_len_m; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      sdram_rd_ack = 1'b1;
      e.c = cyc + RD_DLY;
      e.d = 16'($urandom);
      sched.push_back(e);
      if (try_drop && i == 0) begin
        cli_rd_req = 1'b1;
        cli_rd_addr = 24'($urandom);
        cli_rd_len = 9'd3;
      end
      tick();
      sdram_rd_ack = 1'b0;
      cli_rd_req = 1'b0;
    end
    tick();
    check("rd_req_drop", {31'd0, sdram_rd_req}, 0);
  endtask

  // Serve every request the model says must issue, in the order it must issue.
  task automatic service(bit try_drop);
    int kind, exp;
    bit urgent;
    sdram_busy = 1'b0;
    for (int n = 0; n < 20; n++) begin
      urgent = (wq.size() >= DEPTH - BL);
      if (rd_pend_m && !(wr_ready_m() && urgent)) exp = 1;
      else if (wr_ready_m()) exp = 2;
      else break;
      wait_req(kind);
      check("req_kind", kind, exp);
      if (kind != exp) break;
      if (kind == 1) serve_read(try_drop);
      else serve_write();
    end
    repeat (8) tick();
    check("idle_rd_req", {31'd0, sdram_rd_req}, 0);
    check("idle_wr_req", {31'd0, sdram_wr_req}, 0);
    check("idle_rd_busy", {31'd0, cli_rd_busy}, 0);
  endtask

  task automatic check_reset_outputs(string pfx);
    check({pfx, "_wr_req"},   {31'd0, sdram_wr_req}, 0);
    check({pfx, "_rd_req"},   {31'd0, sdram_rd_req}, 0);
    check({pfx, "_rd_valid"}, {31'd0, cli_rd_valid}, 0);
    check({pfx, "_rd_busy"},  {31'd0, cli_rd_busy}, 0);
    check({pfx, "_ovf"},      {31'd0, cli_ovf}, 0);
    check({pfx, "_rd_data"},  {16'd0, cli_rd_data}, 0);
    check({pfx, "_full"},     {31'd0, cli_wr_full}, 0);
    check({pfx, "_wr_addr"},  {8'd0, sdram_wr_addr}, {8'd0, WR_BASE});
    check({pfx, "_rd_addr"},  {8'd0, sdram_rd_addr}, 0);
    check({pfx, "_wr_bytes"}, {23'd0, sdwr_bytes}, BL);
    check({pfx, "_rd_bytes"}, {23'd0, sdrd_bytes}, 0);
  endtask

  initial begin
    int kind, n;
    rst_n = 1'b0;
    cli_wr_en = 1'b0; cli_wr_data = '0; cli_flush = 1'b0;
    cli_rd_req = 1'b0; cli_rd_addr = '0; cli_rd_len = '0;
    sdram_init_done = 1'b0; sdram_busy = 1'b0;
    sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0;
    wptr_m = WR_BASE; flush_m = 1'b0; rd_pend_m = 1'b0; rd_addr_m = '0; rd_len_m = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check_reset_outputs("reset");

    // Initialisation gating and request latency
    repeat (16) push_word();
    repeat (4) tick();
    check("gate_no_req", {31'd0, sdram_wr_req}, 0);
    sdram_init_done = 1'b1;
    tick();
    check("req_latency", {31'd0, sdram_wr_req}, 1);
    service(1'b0);
    repeat (16) push_word();
    service(1'b0);
    repeat (16) push_word();
    service(1'b0);

    // Directed read
    pulse_read(24'h400200, 9'd4);
    service(1'b0);

    // Read and write pending together; a second read is dropped
    sdram_busy = 1'b1;
    repeat (16) push_word();
    pulse_read(24'($urandom), 9'($urandom_range(1, 8)));
    service(1'b1);

    // Near-full FIFO: writes win over a pending read
    sdram_busy = 1'b1;
    while (wq.size() < 50) push_word();
    pulse_read(24'($urandom), 9'($urandom_range(1, 8)));
    service(1'b0);

    // Flush of a partial burst, then confirm the flag cleared
    pulse_flush();
    service(1'b0);
    repeat (5) push_word();
    pulse_flush();
    service(1'b0);
    repeat (3) push_word();
    repeat (10) tick();
    check("flush_cleared", {31'd0, sdram_wr_req}, 0);
    pulse_flush();
    service(1'b0);
    pulse_flush();
    repeat (3) push_word();
    repeat (10) tick();
    check("flush_empty_clr", {31'd0, sdram_wr_req}, 0);
    pulse_flush();
    service(1'b0);

    // Randomised mix
    for (int it = 0; it < 15; it++) begin
      sdram_busy = 1'b1;
      n = DEPTH - wq.size();
      if (n > 30) n = 30;
      n = $urandom_range(0, n);
      repeat (n) push_word();
      if ($urandom_range(0, 1) == 1) pulse_read(24'($urandom), 9'($urandom_range(0, 12)));
      if ($urandom_range(0, 2) == 0) pulse_flush();
      service(1'($urandom_range(0, 1)));
    end

    // Overflow, then reset in the middle of a burst
    sdram_busy = 1'b1;
    while (wq.size() < DEPTH) push_word();
    tick();
    check("full_at_depth", {31'd0, cli_wr_full}, 1);
    check("ovf_before", {31'd0, cli_ovf}, 0);
    push_word();
    check("ovf_set", {31'd0, cli_ovf}, 1);
    check("full_hold", {31'd0, cli_wr_full}, 1);
    sdram_busy = 1'b0;
    wait_req(kind);
    check("ovf_req_kind", kind, 2);
    check("ovf_wr_addr", {8'd0, sdram_wr_addr}, {8'd0, wptr_m});
    for (int i = 0; i < 3; i++) begin
      sdram_wr_ack = 1'b1;
      check("ovf_wr_data", {16'd0, sdram_wr_data}, {16'd0, wq[0]});
      void'(wq.pop_front());
      tick();
    end
    sdram_wr_ack = 1'b0;
    rst_n = 1'b0;
    tick();
    check_reset_outputs("midrst");
    wq.delete();
    wptr_m = WR_BASE; flush_m = 1'b0; rd_pend_m = 1'b0;
    rst_n = 1'b1;
    tick();
    pulse_flush();
    repeat (5) tick();
    check("fifo_discarded", {31'd0, sdram_wr_req}, 0);
    repeat (16) push_word();
    service(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit (tests=%0d fails=%0d)", tests, fails);
    $fatal(1, "watchdog");
  end
endmodule
